video_fetch_align: RTL and testbench
====================================

Name: video_fetch_align

Overview:
- Downstream consumer of the display driver core's timing outputs: h_blank, h_sync, v_blank, v_sync and the pixel address.
- Turns each active-pixel address into a synchronous read of packed framebuffer memory, then unpacks the addressed pixel.
- Delays the sync/blank strobes so they leave the block cycle-aligned with pixel data.
- Also produces a frame-start pulse and a frame counter for software/debug.

Parameters:
- ADDR_W, 19, width of the incoming pixel address.
- WORD_W, 8, memory data word width.
- PIX_W, 4, bits per pixel. WORD_W/PIX_W (PPW) must be a power of 2 and at least 2.
- MEM_LAT, 1, memory read latency in cycles, from mem_rd sampled by the memory to mem_data valid. Range 1..4.
- BORDER, 0, pixel value driven while blanked.
- HS_POL, 0, active level of h_sync_out.
- VS_POL, 0, active level of v_sync_out.
- FC_W, 8, frame counter width.

Ports:
- clk  in  1  pixel clock (the divided clock feeding the driver core)
- rst  in  1  synchronous, active-high reset
- h_blank_in  in  1  active-high horizontal blank from the driver core
- v_blank_in  in  1  active-high vertical blank
- h_sync_in  in  1  active-high horizontal sync
- v_sync_in  in  1  active-high vertical sync
- addr_in  in  ADDR_W  linear pixel address
- mem_addr  out  ADDR_W-log2(PPW)  word address to the framebuffer
- mem_rd  out  1  read strobe
- mem_data  in  WORD_W  read data, valid MEM_LAT cycles after mem_rd
- pix  out  PIX_W  pixel value
- de  out  1  display enable (active pixel)
- h_sync_out  out  1  aligned horizontal sync, polarity set by HS_POL
- v_sync_out  out  1  aligned vertical sync, polarity set by VS_POL
- frame_start  out  1  one-cycle pulse aligned with the v_sync_out assert edge
- frame_cnt  out  FC_W  count of frames

Behaviour:
- active = ~h_blank_in & ~v_blank_in. Decompose addr_in as follows:
  - word = addr_in >> log2(PPW)
  - sel = low log2(PPW) bits of addr_in
  - pixel sel occupies data bits [sel*PIX_W +: PIX_W] (pixel 0 in the LSBs).
- Stage 0 (registered):
  - Compute reuse = active & tag_valid & (word == tag).
  - mem_rd <= active & ~reuse.
  - mem_addr <= word whenever active; otherwise hold its value.
  - When active, tag <= word and tag_valid <= 1. When not active, tag_valid <= 0.
- Stages 1..MEM_LAT:
  - Carry valid, reuse, sel, blank and sync bits through a shift register of depth MEM_LAT.
- Output stage (registered):
  - When the issued read returns, capture mem_data into hold_word.
  - Select source word: reuse ? hold_word : mem_data.
  - pix <= active ? selected pixel : BORDER.
  - de <= active.
  - h_sync_out <= h_sync_in ^ ~HS_POL; v_sync_out <= v_sync_in ^ ~VS_POL (delayed copies of the inputs).
- Latency: inputs at cycle N appear on pix/de/syncs at cycle N+MEM_LAT+2, fixed. Blank, sync and pixel stay mutually aligned.
- frame_start: rising edge of the delayed v_sync_in, i.e. 1 in the same cycle v_sync_out first goes active. frame_cnt increments in that same cycle and wraps 2^FC_W-1 -> 0.
- Reads are issued only for active pixels. One read per word while addresses stay within the word. A new read is forced after any blank cycle, even for the same word.
- Non-sequential address jumps (word != tag) always issue a read. There is no ordering assumption on addr_in.
- Reset, all outputs:
  - mem_rd=0, mem_addr=0, pix=BORDER, de=0
  - h_sync_out=~HS_POL, v_sync_out=~VS_POL
  - frame_start=0, frame_cnt=0
- Reset, internal state: tag_valid=0, hold_word=0, all pipeline valid/reuse bits=0, delayed syncs cleared to inactive.
- Reset mid-frame: in-flight reads are discarded and mem_data is ignored until a post-reset read returns. Outputs stay at reset values for MEM_LAT+2 cycles after rst falls.
- A v_sync_in already high when rst falls produces no frame_start until its next rising edge.

Decomposition:
- Package video_pkg holds:
  - localparams: PPW, SEL_W = log2(PPW), MADDR_W = ADDR_W-SEL_W.
  - an enum or typedef for the pipeline record {valid, reuse, sel, hb, vb, hs, vs}.
- Sub-module pipe_delay (params WIDTH, DEPTH, RESET_VAL):
  - Synchronous-reset shift register.
  - Used for the MEM_LAT-deep side-band pipeline.

Test Plan (defaults, latency 3):
- Active line, addr 0,1,2,3 on consecutive cycles; memory word0=0xA5, word1=0x3C:
  - mem_rd pulses only on cycles 1 and 3, mem_addr=0 then 1.
  - pix = 5,A,C,3 on cycles 3..6, de=1 on those cycles.
- h_blank_in high for 4 cycles mid-line:
  - pix=BORDER and de=0 for exactly those 4 cycles, shifted by 3.
  - First active pixel after blank re-reads its word even if it matches the prior word.
- v_sync_in 0->1 with frame_cnt=0xFF:
  - frame_start=1 for one cycle, 3 cycles later.
  - v_sync_out=0 (VS_POL=0) that cycle.
  - frame_cnt wraps to 0x00.
- Jump addr 7 -> 100 -> 101: reads issued for words 3 and 50 only; pix = word3[7:4], word50[3:0], word50[7:4].
- Assert rst for 1 cycle mid-line with reads in flight:
  - All outputs at reset values for 3 cycles after release.
  - Stale mem_data never appears on pix.
  - First post-reset active pixel triggers mem_rd.
- MEM_LAT=3 build, repeat the first scenario: identical pix sequence with latency 5, syncs still aligned with de.

Source files
------------

// File: rtl/video_fetch_align_pkg.sv
// Shared types and constants for the video fetch/align slice.
package video_pkg;

  localparam int unsigned DEF_ADDR_W = 19;
  localparam int unsigned DEF_WORD_W = 8;
  localparam int unsigned DEF_PIX_W  = 4;

  // Derived values for the default build
  localparam int unsigned PPW     = DEF_WORD_W / DEF_PIX_W;
  localparam int unsigned SEL_W   = $clog2(PPW);
  localparam int unsigned MADDR_W = DEF_ADDR_W - SEL_W;

  // Widest pixel selector carried in the side-band record (up to 256 pixels/word)
  localparam int unsigned SEL_MAX_W = 8;

  // Side-band record travelling alongside an outstanding memory read
  typedef struct packed {
    logic                 valid;
    logic                 reuse;
    logic                 vrise;
    logic [SEL_MAX_W-1:0] sel;
    logic                 hb;
    logic                 vb;
    logic                 hs;
    logic                 vs;
  } pipe_rec_t;

  // Idle record: blanked, syncs inactive, nothing in flight
  localparam pipe_rec_t REC_IDLE = '{
    valid: 1'b0, reuse: 1'b0, vrise: 1'b0, sel: '0,
    hb: 1'b1, vb: 1'b1, hs: 1'b0, vs: 1'b0
  };

  function automatic int unsigned sel_width(input int unsigned word_w,
                                            input int unsigned pix_w);
    return $clog2(word_w / pix_w);
  endfunction

endpackage

// File: rtl/video_fetch_align_pipe_delay.sv
// Fixed-depth shift register with synchronous reset.
module pipe_delay #(
  parameter int unsigned      WIDTH     = 8,
  parameter int unsigned      DEPTH     = 1,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  logic [WIDTH-1:0] r_sr [DEPTH];

  // Shift one stage per clock; reset loads every stage with RESET_VAL
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) r_sr[i] <= RESET_VAL;
    end else begin
      r_sr[0] <= i_d;
      for (int unsigned i = 1; i < DEPTH; i++) r_sr[i] <= r_sr[i-1];
    end
  end

  assign o_q = r_sr[DEPTH-1];

endmodule

// File: rtl/video_fetch_align.sv
// Framebuffer fetch and pixel unpack, with sync/blank delayed to match read latency.
module video_fetch_align
  import video_pkg::*;
#(
  parameter int unsigned      ADDR_W  = DEF_ADDR_W,
  parameter int unsigned      WORD_W  = DEF_WORD_W,
  parameter int unsigned      PIX_W   = DEF_PIX_W,
  parameter int unsigned      MEM_LAT = 1,
  parameter logic [PIX_W-1:0] BORDER  = '0,
  parameter bit               HS_POL  = 1'b0,
  parameter bit               VS_POL  = 1'b0,
  parameter int unsigned      FC_W    = 8
) (
  input  logic                                          clk,
  input  logic                                          rst,
  input  logic                                          h_blank_in,
  input  logic                                          v_blank_in,
  input  logic                                          h_sync_in,
  input  logic                                          v_sync_in,
  input  logic [ADDR_W-1:0]                             addr_in,
  output logic [ADDR_W-sel_width(WORD_W, PIX_W)-1:0]    mem_addr,
  output logic                                          mem_rd,
  input  logic [WORD_W-1:0]                             mem_data,
  output logic [PIX_W-1:0]                              pix,
  output logic                                          de,
  output logic                                          h_sync_out,
  output logic                                          v_sync_out,
  output logic                                          frame_start,
  output logic [FC_W-1:0]                               frame_cnt
);

  localparam int unsigned L_SEL_W   = sel_width(WORD_W, PIX_W);
  localparam int unsigned L_MADDR_W = ADDR_W - L_SEL_W;

  logic                 w_active;
  logic [L_MADDR_W-1:0] w_word;
  logic                 w_reuse;
  logic                 w_vrise;
  pipe_rec_t            w_s0_next;
  pipe_rec_t            r_s0;
  pipe_rec_t            w_pd;
  logic                 r_tag_valid;
  logic                 r_vs_prev;
  logic [WORD_W-1:0]    r_hold;
  logic                 w_out_act;
  logic [WORD_W-1:0]    w_src;
  logic [WORD_W-1:0]    w_shift;

  // Stage-0 decode: word/pixel split, reuse test and v_sync rise detect.
  // mem_addr only changes on active cycles, so it doubles as the word tag.
  always_comb begin
    w_active  = ~h_blank_in & ~v_blank_in;
    w_word    = addr_in[ADDR_W-1:L_SEL_W];
    w_reuse   = w_active & r_tag_valid & (w_word == mem_addr);
    w_vrise   = v_sync_in & ~r_vs_prev;
    w_s0_next = '{
      valid: w_active,
      reuse: w_reuse,
      vrise: w_vrise,
      sel:   SEL_MAX_W'(addr_in[L_SEL_W-1:0]),
      hb:    h_blank_in,
      vb:    v_blank_in,
      hs:    h_sync_in,
      vs:    v_sync_in
    };
  end

  // Stage 0: issue reads and register the side-band record.
  // r_vs_prev resets high so a v_sync already asserted at reset release is not a rise.
  always_ff @(posedge clk) begin
    if (rst) begin
      mem_rd      <= 1'b0;
      mem_addr    <= '0;
      r_tag_valid <= 1'b0;
      r_vs_prev   <= 1'b1;
      r_s0        <= REC_IDLE;
    end else begin
      mem_rd      <= w_active & ~w_reuse;
      if (w_active) mem_addr <= w_word;
      r_tag_valid <= w_active;
      r_vs_prev   <= v_sync_in;
      r_s0        <= w_s0_next;
    end
  end

  pipe_delay #(
    .WIDTH    ($bits(pipe_rec_t)),
    .DEPTH    (MEM_LAT),
    .RESET_VAL(REC_IDLE)
  ) u_side (
    .i_clk(clk),
    .i_rst(rst),
    .i_d  (r_s0),
    .o_q  (w_pd)
  );

  // Output-stage source word and pixel extraction
  always_comb begin
    w_out_act = ~w_pd.hb & ~w_pd.vb;
    w_src     = w_pd.reuse ? r_hold : mem_data;
    w_shift   = w_src >> (32'(w_pd.sel) * PIX_W);
  end

  // Output stage: capture returned words, drive pixel, syncs and frame tracking
  always_ff @(posedge clk) begin
    if (rst) begin
      r_hold      <= '0;
      pix         <= BORDER;
      de          <= 1'b0;
      h_sync_out  <= ~HS_POL;
      v_sync_out  <= ~VS_POL;
      frame_start <= 1'b0;
      frame_cnt   <= '0;
    end else begin
      if (w_pd.valid && !w_pd.reuse) r_hold <= mem_data;
      pix         <= w_out_act ? w_shift[PIX_W-1:0] : BORDER;
      de          <= w_out_act;
      h_sync_out  <= w_pd.hs ^ ~HS_POL;
      v_sync_out  <= w_pd.vs ^ ~VS_POL;
      frame_start <= w_pd.vrise;
      if (w_pd.vrise) frame_cnt <= frame_cnt + FC_W'(1);
    end
  end

endmodule

// File: tb/tb_video_fetch_align.sv
// Bench for video_fetch_align: MEM_LAT=1 and MEM_LAT=3 instances share stimulus.
module tb_video_fetch_align;

  localparam int HMAX = 16384;

  typedef struct {
    logic        rst;
    logic        hb;
    logic        vb;
    logic        hs;
    logic        vs;
    logic [18:0] addr;
  } stim_t;

  typedef struct {
    stim_t       s;
    logic        chk;
    logic        exp_rd;
    logic [17:0] exp_ma;
    logic        exp_de;
    logic [3:0]  exp_pix;
  } vec_t;

  logic        clk;
  logic        rst, hb, vb, hs, vs;
  logic [18:0] addr;

  logic [17:0] ma1, ma3;
  logic        rd1, rd3;
  logic [7:0]  md1, md3;
  logic [7:0]  m3 [3];
  logic [3:0]  pix1, pix3;
  logic        de1, de3, hso1, hso3, vso1, vso3, fs1, fs3;
  logic [7:0]  fc1, fc3;

  stim_t       hist [HMAX];
  vec_t        tbl  [26];
  int          cyc;
  int          n_chk;
  int          n_err;
  logic [17:0] exp_ma;
  logic [7:0]  fcm [2];

  video_fetch_align #(.MEM_LAT(1)) u_dut1 (
    .clk(clk), .rst(rst), .h_blank_in(hb), .v_blank_in(vb), .h_sync_in(hs),
    .v_sync_in(vs), .addr_in(addr), .mem_addr(ma1), .mem_rd(rd1), .mem_data(md1),
    .pix(pix1), .de(de1), .h_sync_out(hso1), .v_sync_out(vso1),
    .frame_start(fs1), .frame_cnt(fc1)
  );

  video_fetch_align #(.MEM_LAT(3)) u_dut3 (
    .clk(clk), .rst(rst), .h_blank_in(hb), .v_blank_in(vb), .h_sync_in(hs),
    .v_sync_in(vs), .addr_in(addr), .mem_addr(ma3), .mem_rd(rd3), .mem_data(md3),
    .pix(pix3), .de(de3), .h_sync_out(hso3), .v_sync_out(vso3),
    .frame_start(fs3), .frame_cnt(fc3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Framebuffer contents: fixed words 0 and 1, a simple hash elsewhere
  function automatic logic [7:0] mem_word(input logic [17:0] w);
    if (w == 18'd0) return 8'hA5;
    if (w == 18'd1) return 8'h3C;
    return 8'(32'(w) * 29 + 23);
  endfunction

  // Memories return garbage when not reading so stale data is visible
  always @(posedge clk) md1 <= rd1 ? mem_word(ma1) : 8'($urandom);
  always @(posedge clk) begin
    m3[0] <= rd3 ? mem_word(ma3) : 8'($urandom);
    m3[1] <= m3[0];
    m3[2] <= m3[1];
  end
  assign md3 = m3[2];

  // ---------------- reference model over the input history ----------------
  function automatic bit rst_at(input int n);
    if (n < 0) return 1'b1;
    return hist[n].rst;
  endfunction

  function automatic bit act(input int n);
    if (n < 0) return 1'b0;
    return !hist[n].hb && !hist[n].vb;
  endfunction

  function automatic logic [17:0] wrd(input int n);
    return hist[n].addr[18:1];
  endfunction

  // Same word as an active, non-reset previous cycle needs no new read
  function automatic bit reuse(input int n);
    return act(n) && act(n-1) && !rst_at(n-1) && (wrd(n) == wrd(n-1));
  endfunction

  function automatic bit rise(input int n);
    if (n < 1) return 1'b0;
    return hist[n].vs && !hist[n-1].vs && !rst_at(n-1);
  endfunction

  function automatic bit clean(input int k, input int lat);
    for (int j = k - lat; j < k; j++) if (rst_at(j)) return 1'b0;
    return 1'b1;
  endfunction

  function automatic logic [3:0] pix_of(input int n);
    logic [7:0] w;
    w = mem_word(wrd(n));
    return hist[n].addr[0] ? w[7:4] : w[3:0];
  endfunction

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h", nm, cyc, got, exp);
    end
  endtask

  task automatic check_out(input int di, input string tag, input int k, input int lat,
                           input logic [3:0] p, input logic d, input logic ho,
                           input logic vo, input logic f, input logic [7:0] fc);
    bit         c;
    int         n;
    bit         e_de, e_fs;
    logic [3:0] e_pix;
    c     = clean(k, lat);
    n     = k - lat;
    e_de  = c && act(n);
    e_pix = e_de ? pix_of(n) : 4'h0;
    e_fs  = c && rise(n);
    if (rst_at(k-1)) fcm[di] = 8'h00;
    else if (e_fs) fcm[di] = fcm[di] + 8'h01;
    chk({tag, "_de"},  32'(d), 32'(e_de));
    chk({tag, "_pix"}, 32'(p), 32'(e_pix));
    chk({tag, "_hso"}, 32'(ho), c ? 32'(!hist[n].hs) : 32'd1);
    chk({tag, "_vso"}, 32'(vo), c ? 32'(!hist[n].vs) : 32'd1);
    chk({tag, "_fs"},  32'(f), 32'(e_fs));
    chk({tag, "_fc"},  32'(fc), 32'(fcm[di]));
  endtask

  // Advance to the next sampling point and check both DUTs against the model
  task automatic wait_edge();
    bit e_rd;
    @(negedge clk);
    cyc++;
    if (cyc >= HMAX) begin
      $display("FAIL history_overflow cyc=%0d", cyc);
      $fatal(1);
    end
    e_rd = !rst_at(cyc-1) && act(cyc-1) && !reuse(cyc-1);
    if (rst_at(cyc-1)) exp_ma = '0;
    else if (act(cyc-1)) exp_ma = wrd(cyc-1);
    chk("L1_mem_rd", 32'(rd1), 32'(e_rd));
    chk("L3_mem_rd", 32'(rd3), 32'(e_rd));
    chk("L1_mem_addr", 32'(ma1), 32'(exp_ma));
    chk("L3_mem_addr", 32'(ma3), 32'(exp_ma));
    check_out(0, "L1", cyc, 3, pix1, de1, hso1, vso1, fs1, fc1);
    check_out(1, "L3", cyc, 5, pix3, de3, hso3, vso3, fs3, fc3);
  endtask

  task automatic apply(input stim_t s);
    rst  = s.rst;
    hb   = s.hb;
    vb   = s.vb;
    hs   = s.hs;
    vs   = s.vs;
    addr = s.addr;
    hist[cyc] = s;
  endtask

  task automatic tick(input stim_t s);
    wait_edge();
    apply(s);
  endtask

  function automatic stim_t st(input bit r, input bit h, input bit v,
                               input bit s_hs, input bit s_vs, input int a);
    stim_t s;
    s.rst = r; s.hb = h; s.vb = v; s.hs = s_hs; s.vs = s_vs; s.addr = 19'(a);
    return s;
  endfunction

  function automatic vec_t mk(input bit r, input bit h, input int a, input bit c,
                              input bit rd, input int ma, input bit d, input int p);
    vec_t v;
    v.s       = st(r, h, 1'b0, 1'b0, 1'b0, a);
    v.chk     = c;
    v.exp_rd  = rd;
    v.exp_ma  = 18'(ma);
    v.exp_de  = d;
    v.exp_pix = 4'(p);
    return v;
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog cyc=%0d", cyc);
    $fatal(1);
  end

  initial begin
    stim_t s;
    int    a;
    n_chk = 0; n_err = 0; cyc = -1; exp_ma = '0;
    fcm[0] = 8'h00; fcm[1] = 8'h00;
    rst = 1'b1; hb = 1'b1; vb = 1'b0; hs = 1'b0; vs = 1'b0; addr = '0;

    // Directed vectors for the MEM_LAT=1 instance (expected values at each sample)
    tbl[0]  = mk(1, 1,   0, 1, 0,  0, 0, 0);
    tbl[1]  = mk(1, 1,   0, 1, 0,  0, 0, 0);
    tbl[2]  = mk(0, 1,   0, 1, 0,  0, 0, 0);
    tbl[3]  = mk(0, 1,   0, 1, 0,  0, 0, 0);
    tbl[4]  = mk(0, 0,   0, 1, 0,  0, 0, 0);
    tbl[5]  = mk(0, 0,   1, 1, 1,  0, 0, 0);
    tbl[6]  = mk(0, 0,   2, 1, 0,  0, 0, 0);
    tbl[7]  = mk(0, 0,   3, 1, 1,  1, 1, 5);
    tbl[8]  = mk(0, 1,   0, 1, 0,  1, 1, 4'hA);
    tbl[9]  = mk(0, 1,   0, 1, 0,  1, 1, 4'hC);
    tbl[10] = mk(0, 1,   0, 1, 0,  1, 1, 3);
    tbl[11] = mk(0, 1,   0, 1, 0,  1, 0, 0);
    tbl[12] = mk(0, 0,   3, 1, 0,  1, 0, 0);
    tbl[13] = mk(0, 0,   4, 1, 1,  1, 0, 0);
    tbl[14] = mk(0, 0,   5, 1, 1,  2, 0, 0);
    tbl[15] = mk(0, 1,   0, 1, 0,  2, 1, 3);
    tbl[16] = mk(0, 1,   0, 1, 0,  2, 1, 1);
    tbl[17] = mk(0, 1,   0, 1, 0,  2, 1, 5);
    tbl[18] = mk(0, 1,   0, 1, 0,  2, 0, 0);
    tbl[19] = mk(0, 0,   7, 1, 0,  2, 0, 0);
    tbl[20] = mk(0, 0, 100, 1, 1,  3, 0, 0);
    tbl[21] = mk(0, 0, 101, 1, 1, 50, 0, 0);
    tbl[22] = mk(0, 1,   0, 1, 0, 50, 1, 6);
    tbl[23] = mk(0, 1,   0, 1, 0, 50, 1, 1);
    tbl[24] = mk(0, 1,   0, 1, 0, 50, 1, 4'hC);
    tbl[25] = mk(0, 1,   0, 1, 0, 50, 0, 0);

    for (int i = 0; i < 26; i++) begin
      wait_edge();
      if (tbl[i].chk) begin
        chk("tbl_mem_rd",   32'(rd1),  32'(tbl[i].exp_rd));
        chk("tbl_mem_addr", 32'(ma1),  32'(tbl[i].exp_ma));
        chk("tbl_de",       32'(de1),  32'(tbl[i].exp_de));
        chk("tbl_pix",      32'(pix1), 32'(tbl[i].exp_pix));
      end
      apply(tbl[i].s);
    end

    // v_sync pulses during blank: 260 rises wrap the 8-bit frame counter
    for (int i = 0; i < 260; i++) begin
      tick(st(0, 1, 1, 0, 1, 0));
      tick(st(0, 1, 1, 0, 1, 0));
      tick(st(0, 1, 1, 0, 0, 0));
      tick(st(0, 1, 1, 0, 0, 0));
    end
    for (int i = 0; i < 6; i++) tick(st(0, 1, 1, 0, 0, 0));
    wait_edge();
    chk("fc_wrap_L1", 32'(fc1), 32'd4);
    chk("fc_wrap_L3", 32'(fc3), 32'd4);
    apply(st(0, 1, 1, 0, 0, 0));

    // v_sync already high when reset releases: no frame_start until the next rise
    tick(st(0, 1, 1, 0, 1, 0));
    tick(st(1, 1, 1, 0, 1, 0));
    tick(st(1, 1, 1, 0, 1, 0));
    for (int i = 0; i < 8; i++) begin
      wait_edge();
      chk("fs_held_L1", 32'(fs1), 32'd0);
      chk("fs_held_L3", 32'(fs3), 32'd0);
      apply(st(0, 1, 1, 0, 1, 0));
    end
    tick(st(0, 1, 1, 0, 0, 0));
    tick(st(0, 1, 1, 0, 0, 0));
    for (int i = 0; i < 3; i++) tick(st(0, 1, 1, 0, 1, 0));
    for (int i = 0; i < 6; i++) tick(st(0, 1, 1, 0, 0, 0));

    // Reset pulse mid-line with reads in flight
    a = 40;
    for (int i = 0; i < 10; i++) begin
      tick(st(0, 0, 0, 0, 0, a));
      a++;
    end
    tick(st(1, 0, 0, 0, 0, a));
    for (int i = 0; i < 3; i++) begin
      wait_edge();
      chk("rst_de_L1",  32'(de1),  32'd0);
      chk("rst_pix_L1", 32'(pix1), 32'd0);
      chk("rst_hso_L1", 32'(hso1), 32'd1);
      if (i == 1) chk("rst_first_rd", 32'(rd1), 32'd1);
      apply(st(0, 0, 0, 0, 0, a));
      a++;
    end
    for (int i = 0; i < 6; i++) tick(st(0, 1, 0, 0, 0, 0));

    // Randomized traffic: mostly sequential addresses with repeats, jumps, blanks, resets
    a = 0;
    for (int i = 0; i < 2000; i++) begin
      int r;
      r = $urandom_range(0, 9);
      if (r < 6) a = a + 1;
      else if (r >= 8) a = $urandom_range(0, 127);
      s = st(($urandom_range(0, 199) == 0), ($urandom_range(0, 3) == 0),
             ($urandom_range(0, 15) == 0), ($urandom_range(0, 5) == 0),
             ($urandom_range(0, 7) == 0), a);
      tick(s);
    end
    for (int i = 0; i < 8; i++) tick(st(0, 1, 1, 0, 0, 0));

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
